liteeth_sram_1rw1r_param: RTL
=============================

Name: liteeth_sram_1rw1r_param

Overview:
Parametrised single-clock behavioural SRAM with one read/write port (port 0) and one read-only port (port 1). It is the successor to the fixed 48x32 LiteEth macro model. Over that model it adds:
- configurable width and depth;
- per-lane write mask;
- selectable write mode;
- optional second output pipeline stage;
- same-cycle write-to-read forwarding;
- read-valid strobes.

It sits under the LiteEth MAC buffers, where it replaces per-size SRAM models for synthesis-free simulation and FPGA mapping.

Parameters:
- BITS, 48, data word width.
- WORD_DEPTH, 32, number of words. Need not be a power of two.
- ADDR_WIDTH, $clog2(WORD_DEPTH), address width.
- MASK_GRAN, 8, bits per write-mask lane.
- WMASK_WIDTH, (BITS+MASK_GRAN-1)/MASK_GRAN, number of mask lanes. The top lane may be partial.
- WRITE_MODE, 0, port-0 read behaviour on a write: 0 read_first, 1 write_first, 2 no_change.
- READ_LATENCY, 1, cycles from access to dout. Legal values are 1 or 2; any other value is a $fatal at elaboration.
- FWD_EN, 1, controls port 1 reading the address port 0 writes in the same cycle: 1 returns the new merged word, 0 returns the old word.

Ports:
- clk  input  1  single clock for both ports.
- rst_n  input  1  asynchronous active-low reset.
- csb0  input  1  port-0 chip select, active low.
- web0  input  1  port-0 write enable, active low. Only meaningful when csb0=0.
- wmask0  input  WMASK_WIDTH  lane write enables, active high.
- addr0  input  ADDR_WIDTH  port-0 address.
- din0  input  BITS  port-0 write data.
- dout0  output  BITS  port-0 read data.
- dvalid0  output  1  one-cycle pulse when dout0 is updated.
- csb1  input  1  port-1 chip select, active low.
- addr1  input  ADDR_WIDTH  port-1 address.
- dout1  output  BITS  port-1 read data.
- dvalid1  output  1  one-cycle pulse when dout1 is updated.

Behaviour:
- Reset: rst_n is asynchronous and active low. On assertion, dout0, dout1, dvalid0, dvalid1, all pipeline stages and the pending flags go to 0 immediately. Memory contents are not reset.
- Accesses issued in the cycle rst_n deasserts are honoured.
- Reset mid-pipeline drops the in-flight read: no dvalid is produced for it afterwards.
- Access: port 0 or 1 is active when its csb is 0 at a posedge clk. When csb=1 the port's dout holds its value and dvalid is 0.
- Write: csb0=0 and web0=0. For each lane i with wmask0[i]=1, mem[addr0][lane i] <= din0[lane i]. Unmasked lanes keep their old value. A write with wmask0=0 leaves memory unchanged but still counts as a write for WRITE_MODE.
- Port-0 read data, stage 1:
  - Read (web0=1): mem[addr0].
  - Write with WRITE_MODE=0: the pre-write word.
  - Write with WRITE_MODE=1: the merged post-write word.
  - Write with WRITE_MODE=2: no read. Stage 1 holds and no dvalid0 is generated.
- Port-1 read data, stage 1: mem[addr1]. If port 0 writes addr1 in the same cycle:
  - FWD_EN=1 returns the merged new word.
  - FWD_EN=0 returns the old word.
- Latency:
  - READ_LATENCY=1: dout and dvalid update at the edge of the access, so data is visible in the next cycle.
  - READ_LATENCY=2: a pending flag registers each port's read. Stage 2 loads from stage 1 only when the flag is set, so dout and dvalid appear one cycle later.
  - Back-to-back reads stream at full rate, one word per cycle.
- Out-of-range address (addr >= WORD_DEPTH):
  - Writes are ignored.
  - Reads return all zeros and still pulse dvalid.
  - In simulation only, a $display warning is issued under SRAM_MONITOR.
- Simultaneous same-address reads on both ports (no write) both return the stored word.
- Memory is declared as a plain reg array with no reset, so FPGA tools can infer block RAM. Forwarding is done by muxing in the merged word, never by an extra read.
- SRAM_MONITOR: $display each write (time, addr0, wmask0, din0).

Test Plan:
- Reset, then read addr 5 on both ports with default parameters → dout0=dout1=0 while rst_n=0. After reset, write 48'h1234_5678_9ABC to addr 5 with wmask=6'h3F, then read addr 5 on port 1 → dout1=48'h1234_5678_9ABC and dvalid1 pulses one cycle after the access.
- Mask merge: addr 3 holds 48'hFFFF_FFFF_FFFF. Write din0=0 with wmask0=6'b000101 → readback 48'hFFFF_FFFF_FF00 with byte 2 also cleared, i.e. 48'hFFFF_FF00_FF00.
- WRITE_MODE sweep: addr 7 holds 48'hAA, then write 48'hBB to addr 7 on port 0 with wmask0=6'h3F.
  - Mode 0 → dout0=48'hAA with dvalid0=1.
  - Mode 1 → dout0=48'hBB with dvalid0=1.
  - Mode 2 → dout0 keeps its previous value and dvalid0=0.
- Forwarding: same cycle, port 0 writes 48'h55 to addr 9 (old value 48'h11) and port 1 reads addr 9 → FWD_EN=1 gives dout1=48'h55; FWD_EN=0 gives dout1=48'h11.
- READ_LATENCY=2: port 1 reads addr 0..3 back-to-back → dvalid1 is high for 4 consecutive cycles starting 2 cycles after the first access, and data is in order. Assert rst_n low for one cycle mid-burst → dout1=0 immediately and no further dvalid1.
- WORD_DEPTH=20, ADDR_WIDTH=5: write to addr 25, then read addr 25 → dout=0 and dvalid pulses. Read addr 19 → its previously written value, unchanged.

Source files
------------

// File: rtl/liteeth_sram_1rw1r_param.sv
// Parametrised single-clock SRAM: port 0 read/write with lane mask, port 1 read-only.
// Optional second output stage, same-cycle write forwarding to port 1, read-valid strobes.
module liteeth_sram_1rw1r_param #(
    parameter int BITS         = 48,
    parameter int WORD_DEPTH   = 32,
    parameter int ADDR_WIDTH   = $clog2(WORD_DEPTH),
    parameter int MASK_GRAN    = 8,
    parameter int WMASK_WIDTH  = (BITS + MASK_GRAN - 1) / MASK_GRAN,
    parameter int WRITE_MODE   = 0,
    parameter int READ_LATENCY = 1,
    parameter int FWD_EN       = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   csb0,
    input  logic                   web0,
    input  logic [WMASK_WIDTH-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0]  addr0,
    input  logic [BITS-1:0]        din0,
    output logic [BITS-1:0]        dout0,
    output logic                   dvalid0,
    input  logic                   csb1,
    input  logic [ADDR_WIDTH-1:0]  addr1,
    output logic [BITS-1:0]        dout1,
    output logic                   dvalid1
);

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $fatal(1, "liteeth_sram_1rw1r_param: READ_LATENCY must be 1 or 2");
    end

    reg [BITS-1:0] mem [0:WORD_DEPTH-1];

    logic            in0, in1, wr0, rd0_en, rd1_en, fwd;
    logic [BITS-1:0] bmask, old0, old1, merged0, rd0_data, rd1_data;

    always_comb begin
        bmask = '0;
        for (int b = 0; b < BITS; b++) begin
            bmask[b] = wmask0[b / MASK_GRAN];
        end
    end

    assign in0     = int'(addr0) < WORD_DEPTH;
    assign in1     = int'(addr1) < WORD_DEPTH;
    assign old0    = in0 ? mem[addr0] : '0;
    assign old1    = in1 ? mem[addr1] : '0;
    assign merged0 = (old0 & ~bmask) | (din0 & bmask);

    assign wr0      = !csb0 && !web0;
    assign rd0_en   = !csb0 && !(wr0 && WRITE_MODE == 2);
    // Write-first on an out-of-range address reads back zeros, like any out-of-range read.
    assign rd0_data = (wr0 && WRITE_MODE == 1) ? (in0 ? merged0 : '0) : old0;

    assign fwd      = (FWD_EN != 0) && wr0 && in0 && (addr0 == addr1);
    assign rd1_en   = !csb1;
    assign rd1_data = fwd ? merged0 : old1;

    always_ff @(posedge clk) begin
        if (wr0 && in0) begin
            mem[addr0] <= merged0;
        end
    end

`ifdef SRAM_MONITOR
    always @(posedge clk) begin
        if (wr0) begin
            $display("%0t sram write addr=%0d wmask=%h din=%h", $time, addr0, wmask0, din0);
        end
        if ((!csb0 && !in0) || (!csb1 && !in1)) begin
            $display("%0t sram warning: out-of-range access", $time);
        end
    end
`endif

    if (READ_LATENCY == 2) begin : g_lat2
        logic [BITS-1:0] s1_0, s1_1;
        logic            pend0, pend1;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_0    <= '0;
                s1_1    <= '0;
                pend0   <= 1'b0;
                pend1   <= 1'b0;
                dout0   <= '0;
                dout1   <= '0;
                dvalid0 <= 1'b0;
                dvalid1 <= 1'b0;
            end else begin
                pend0   <= rd0_en;
                pend1   <= rd1_en;
                dvalid0 <= pend0;
                dvalid1 <= pend1;
                if (rd0_en) s1_0 <= rd0_data;
                if (rd1_en) s1_1 <= rd1_data;
                if (pend0) dout0 <= s1_0;
                if (pend1) dout1 <= s1_1;
            end
        end
    end else begin : g_lat1
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dout0   <= '0;
                dout1   <= '0;
                dvalid0 <= 1'b0;
                dvalid1 <= 1'b0;
            end else begin
                dvalid0 <= rd0_en;
                dvalid1 <= rd1_en;
                if (rd0_en) dout0 <= rd0_data;
                if (rd1_en) dout1 <= rd1_data;
            end
        end
    end

endmodule
